// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Imported by fifo_dpram and fifo_sync_param.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Ceiling log2 for sizing address/pointer fields at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// WIDTH x DEPTH storage with one synchronous write port and one registered read port.
// Read data resets to zero; array contents are never cleared.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEFAULT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A read of the slot being written on the same edge returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count and registered flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERRFLAG_EN is defined.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        Din,
  input  logic                    Wen,
  input  logic                    Ren,
  output logic [WIDTH-1:0]        Dout,
  output logic                    Fempty,
  output logic                    Ffull,
  output logic                    Falmost_empty,
  output logic                    Falmost_full,
  output logic [clog2(DEPTH):0]   count
`ifdef FIFO_ERRFLAG_EN
  ,
  output logic                    Fovf,
  output logic                    Fudf
`endif
);

  localparam int          AW     = clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam logic [AW:0] ONE    = CW'(1);
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [AW:0] AE_C   = CW'(AE_LEVEL);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic        empty_q, full_q, aempty_q, afull_q;
  logic        ptr_empty, ptr_full, wr_ok, rd_ok;

  // Wen/Ren are requests, not a valid/ready pair: a read is taken whenever the
  // FIFO holds data, a write whenever there is room or a read frees a slot on
  // the same edge; refused requests are simply dropped.
  always_comb begin
    ptr_empty = (wptr_q == rptr_q);
    ptr_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    rd_ok     = Ren & ~ptr_empty;
    wr_ok     = Wen & (~ptr_full | rd_ok);
    wptr_d    = wr_ok ? wptr_q + ONE : wptr_q;
    rptr_d    = rd_ok ? rptr_q + ONE : rptr_q;
    count_d   = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
      aempty_q <= (count_d <= AE_C);
      afull_q  <= (count_d >= AF_C);
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_ok & ~rst),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (Din),
    .re_i    (rd_ok),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (Dout)
  );

  assign Fempty        = empty_q;
  assign Ffull         = full_q;
  assign Falmost_empty = aempty_q;
  assign Falmost_full  = afull_q;
  assign count         = count_q;

`ifdef FIFO_ERRFLAG_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (Wen & full_q & ~rd_ok);
      udf_q <= udf_q | (Ren & empty_q);
    end
  end

  assign Fovf = ovf_q;
  assign Fudf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (WIDTH=8, DEPTH=16, AF=14, AE=2).
// Compares every cycle against a queue-based reference model; covers FIFO_ERRFLAG_EN when defined.
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] Din;
  logic         Wen, Ren;
  logic [W-1:0] Dout;
  logic         Fempty, Ffull, Falmost_empty, Falmost_full;
  logic [4:0]   count;
`ifdef FIFO_ERRFLAG_EN
  logic         Fovf, Fudf;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fifo_sync_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Din           (Din),
    .Wen           (Wen),
    .Ren           (Ren),
    .Dout          (Dout),
    .Fempty        (Fempty),
    .Ffull         (Ffull),
    .Falmost_empty (Falmost_empty),
    .Falmost_full  (Falmost_full),
    .count         (count)
`ifdef FIFO_ERRFLAG_EN
    ,
    .Fovf          (Fovf),
    .Fudf          (Fudf)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  logic         exp_ovf, exp_udf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO rules applied to an abstract queue of stored words.
  task automatic model_edge(input logic w, input logic r, input logic [W-1:0] d);
    int sz;
    bit rd, wr;
    sz = exp_q.size();
    rd = r && (sz > 0);
    wr = w && ((sz < D) || rd);
    if (w && (sz == D) && !rd) exp_ovf = 1'b1;
    if (r && (sz == 0))        exp_udf = 1'b1;
    if (rd) exp_dout = exp_q.pop_front();
    if (wr) exp_q.push_back(d);
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("dout",         32'(Dout),          32'(exp_dout));
    check("count",        32'(count),         32'(sz));
    check("empty",        32'(Fempty),        32'(sz == 0));
    check("full",         32'(Ffull),         32'(sz == D));
    check("almost_empty", 32'(Falmost_empty), 32'(sz <= AE));
    check("almost_full",  32'(Falmost_full),  32'(sz >= AF));
`ifdef FIFO_ERRFLAG_EN
    check("ovf", 32'(Fovf), 32'(exp_ovf));
    check("udf", 32'(Fudf), 32'(exp_udf));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    Wen = w;
    Ren = r;
    Din = d;
    @(posedge clk);
    model_edge(w, r, d);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic w, input logic r, input logic [W-1:0] d);
    rst = 1'b1;
    Wen = w;
    Ren = r;
    Din = d;
    @(posedge clk);
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    #1;
    rst = 1'b0;
    Wen = 1'b0;
    Ren = 1'b0;
    check_outputs();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         wen;
    logic         ren;
    logic [W-1:0] din;
    logic [W-1:0] e_dout;
    logic [4:0]   e_count;
    logic         e_empty;
    logic         e_full;
    logic         e_ae;
    logic         e_af;
  } vec_t;

  vec_t tbl[11];
  int   pw;

  initial begin
    rst = 1'b1; Wen = 1'b0; Ren = 1'b0; Din = '0;
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;

    // Reset, then idle.
    do_reset(1'b0, 1'b0, 8'h00);

    tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h11, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h22, 8'h00, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h33, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h44, 8'h11, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h22, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h33, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'h44, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h44, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h55, 8'h44, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 8'h55, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wen, tbl[i].ren, tbl[i].din);
      check("tbl_dout",  32'(Dout),          32'(tbl[i].e_dout));
      check("tbl_count", 32'(count),         32'(tbl[i].e_count));
      check("tbl_empty", 32'(Fempty),        32'(tbl[i].e_empty));
      check("tbl_full",  32'(Ffull),         32'(tbl[i].e_full));
      check("tbl_ae",    32'(Falmost_empty), 32'(tbl[i].e_ae));
      check("tbl_af",    32'(Falmost_full),  32'(tbl[i].e_af));
    end

    // Fill to full, then a dropped write.
    do_reset(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check("fill_af", 32'(Falmost_full), 32'(i + 1 >= AF));
    end
    check("fill_full", 32'(Ffull), 32'd1);
    step(1'b1, 1'b0, 8'hAA);
    check("drop_count", 32'(count), 32'd16);
`ifdef FIFO_ERRFLAG_EN
    check("drop_ovf", 32'(Fovf), 32'd1);
`endif

    // Drain in order, then an extra read on empty.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("drain_dout", 32'(Dout), 32'(i));
    end
    check("drain_empty", 32'(Fempty), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("empty_read_hold", 32'(Dout), 32'h0F);

    // Full with simultaneous write and read.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'h55);
    check("full_wr_dout",  32'(Dout),  32'h00);
    check("full_wr_count", 32'(count), 32'd16);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("full_wr_data", 32'(Dout), 32'h55);

    // Empty with simultaneous write and read: no fall-through.
    step(1'b1, 1'b1, 8'h33);
    check("empty_wr_count", 32'(count), 32'd1);
    check("empty_wr_dout",  32'(Dout),  32'h55);
    step(1'b0, 1'b1, 8'h00);
    check("empty_wr_data",  32'(Dout),  32'h33);

    // 24 writes / 24 reads interleaved across the pointer wrap.
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 4; i < 24; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i));
      check("wrap_dout", 32'(Dout), 32'(8'h80 + i - 4));
    end
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 8'h00);
    check("wrap_last", 32'(Dout), 32'h97);

    // Mid-stream reset with a write request held high.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    check("pre_rst_count", 32'(count), 32'd5);
    do_reset(1'b1, 1'b1, 8'hEE);
    check("rst_count", 32'(count),  32'd0);
    check("rst_empty", 32'(Fempty), 32'd1);
    check("rst_dout",  32'(Dout),   32'h00);

    // Randomized traffic with varying write pressure.
    for (int ph = 0; ph < 3; ph++) begin
      pw = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
      for (int i = 0; i < 200; i++) begin
        step(1'($urandom_range(0, 99) < pw),
             1'($urandom_range(0, 99) >= pw),
             8'($urandom_range(0, 255)));
      end
    end
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
